// File: rtl/arm_image_loader.sv
// Program-image loader and run supervisor: streams an image into memory while the
// core is held in reset, then releases it and watches for halt or a run timeout.
module arm_image_loader #(
  parameter int unsigned             DATA_WIDTH     = 32,
  parameter int unsigned             ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
  parameter int unsigned             MAX_WORDS      = 1024,
  parameter int unsigned             TIMEOUT_CYCLES = 100000,
  localparam int unsigned            WCW            = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  output logic                  core_rst,
  input  logic                  halted,
  output logic                  done,
  output logic                  timeout,
  output logic                  overflow,
  output logic [WCW-1:0]        word_count,
  output logic [31:0]           cycle_count
);

  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam logic [WCW-1:0]        MAX_W  = WCW'(MAX_WORDS);
  localparam bit                    TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0]           TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE, ERROR} state_t;

  state_t                state_q;
  logic                  last_q;      // final beat taken; one more LOAD cycle before FLUSH
  logic                  s_ready_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic                  core_rst_q;
  logic                  done_q, timeout_q, overflow_q;
  logic [WCW-1:0]        word_count_q, word_count_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic                  accept;
  logic                  timeout_hit;

  assign accept        = (state_q == LOAD) && s_valid && s_ready_q;
  assign word_count_d  = word_count_q + WCW'(1);
  assign next_addr_d   = next_addr_q + STEP;
  assign cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 32'd1;
  assign timeout_hit   = TO_EN && (cycle_count_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b0;
      s_ready_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= BASE_ADDR;
      mem_data_q    <= '0;
      next_addr_q   <= BASE_ADDR;
      core_rst_q    <= 1'b1;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
      word_count_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_q       <= LOAD;
            last_q        <= 1'b0;
            s_ready_q     <= 1'b1;
            next_addr_q   <= BASE_ADDR;
            core_rst_q    <= 1'b1;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            word_count_q  <= '0;
            cycle_count_q <= '0;
          end
        end
        LOAD: begin
          if (last_q) begin
            state_q <= FLUSH;
          end else if (accept) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= next_addr_q;
            mem_data_q   <= s_data;
            next_addr_q  <= next_addr_d;
            word_count_q <= word_count_d;
            if (s_last) begin
              last_q    <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              s_ready_q <= (word_count_d < MAX_W);
            end
          end else if (s_valid && (word_count_q == MAX_W)) begin
            // Image is larger than capacity: abort with the core still in reset.
            state_q    <= ERROR;
            s_ready_q  <= 1'b0;
            overflow_q <= 1'b1;
          end
        end
        FLUSH: begin
          state_q    <= RUN;
          last_q     <= 1'b0;
          core_rst_q <= 1'b0;
        end
        RUN: begin
          cycle_count_q <= cycle_count_d;
          if (halted) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (timeout_hit) begin
            state_q    <= ERROR;
            timeout_q  <= 1'b1;
            core_rst_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_q;
  assign mem_write_en = mem_we_q;
  assign core_rst     = core_rst_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign word_count   = word_count_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_arm_image_loader.sv
// Bench for arm_image_loader: four parameterisations, scoreboard of expected memory
// writes checked on every write strobe, plus per-scenario status checks.
module tb_arm_image_loader;

  localparam int          DW_T   [4] = '{32, 32, 64, 64};
  localparam int          AW_T   [4] = '{32, 32, 12, 12};
  localparam logic [31:0] BASE_T [4] = '{32'h0, 32'h0, 32'h100, 32'hFF8};
  localparam int          MAXW_T [4] = '{1024, 2, 4, 4};
  localparam int          TO_T   [4] = '{100000, 5, 100000, 100000};

  logic        clk;
  logic        rst_n   [4];
  logic        start   [4];
  logic        s_valid [4];
  logic        s_last  [4];
  logic        halted  [4];
  logic [63:0] s_data  [4];

  wire         s_ready     [4];
  wire         mem_we      [4];
  wire         core_rst    [4];
  wire         done        [4];
  wire         timeout     [4];
  wire         overflow    [4];
  wire [31:0]  mem_addr    [4];
  wire [63:0]  mem_data    [4];
  wire [31:0]  word_count  [4];
  wire [31:0]  cycle_count [4];

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [63:0] v;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      localparam int DW  = DW_T[gi];
      localparam int AW  = AW_T[gi];
      localparam int WCW = $clog2(MAXW_T[gi] + 1);
      wire [AW-1:0]  ma;
      wire [DW-1:0]  md;
      wire [WCW-1:0] wc;
      arm_image_loader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (BASE_T[gi][AW-1:0]),
        .MAX_WORDS     (MAXW_T[gi]),
        .TIMEOUT_CYCLES(TO_T[gi])
      ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n[gi]),
        .start       (start[gi]),
        .s_valid     (s_valid[gi]),
        .s_data      (s_data[gi][DW-1:0]),
        .s_last      (s_last[gi]),
        .s_ready     (s_ready[gi]),
        .mem_addr    (ma),
        .mem_data_in (md),
        .mem_write_en(mem_we[gi]),
        .core_rst    (core_rst[gi]),
        .halted      (halted[gi]),
        .done        (done[gi]),
        .timeout     (timeout[gi]),
        .overflow    (overflow[gi]),
        .word_count  (wc),
        .cycle_count (cycle_count[gi])
      );
      assign mem_addr[gi]   = 32'(ma);
      assign mem_data[gi]   = 64'(md);
      assign word_count[gi] = 32'(wc);
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (mem_we[d] === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL write_unexpected: dut=%0d got write addr=%h data=%h, want no write", d, mem_addr[d], mem_data[d]);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.d != d || mon_e.a !== mem_addr[d] || mon_e.v !== mem_data[d]) begin
            n_err++;
            $display("FAIL write_data: dut=%0d got addr=%h data=%h, want dut=%0d addr=%h data=%h", d, mem_addr[d], mem_data[d], mon_e.d, mon_e.a, mon_e.v);
          end else begin
            $display("write dut=%0d addr=%h data=%h", d, mem_addr[d], mem_data[d]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] exp_addr(int d, int i);
    logic [31:0] m;
    m = (AW_T[d] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << AW_T[d]) - 32'd1);
    return (BASE_T[d] + 32'(i * (DW_T[d] / 8))) & m;
  endfunction

  function automatic logic [63:0] dmask(int d, logic [63:0] v);
    return (DW_T[d] == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  task automatic push_exp(int d, int i, logic [63:0] v);
    wr_t e;
    e.d = d;
    e.a = exp_addr(d, i);
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(int d);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Back-to-back beats; only the first nexp are expected to reach memory.
  task automatic send(int d, int n, bit last, int nexp, logic [63:0] d0);
    for (int i = 0; i < n; i++) begin
      s_valid[d] = 1'b1;
      s_data[d]  = dmask(d, d0 + 64'(i));
      s_last[d]  = last && (i == n - 1);
      if (i < nexp) push_exp(d, i, dmask(d, d0 + 64'(i)));
      @(negedge clk);
    end
    s_valid[d] = 1'b0;
    s_last[d]  = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if (core_rst[d] !== 1'b1) begin n_err++; $display("FAIL reset_core_rst dut=%0d: got %b want 1", d, core_rst[d]); end
      n_cmp++; if (s_ready[d] !== 1'b0 || mem_we[d] !== 1'b0) begin n_err++; $display("FAIL reset_ready_we dut=%0d: got %b%b want 00", d, s_ready[d], mem_we[d]); end
      n_cmp++; if (mem_addr[d] !== BASE_T[d]) begin n_err++; $display("FAIL reset_addr dut=%0d: got %h want %h", d, mem_addr[d], BASE_T[d]); end
      n_cmp++; if (mem_data[d] !== 64'h0) begin n_err++; $display("FAIL reset_data dut=%0d: got %h want 0", d, mem_data[d]); end
      n_cmp++; if (word_count[d] !== 32'd0 || cycle_count[d] !== 32'd0) begin n_err++; $display("FAIL reset_counts dut=%0d: got %0d/%0d want 0/0", d, word_count[d], cycle_count[d]); end
      n_cmp++; if ({done[d], timeout[d], overflow[d]} !== 3'b000) begin n_err++; $display("FAIL reset_flags dut=%0d: got %b%b%b want 000", d, done[d], timeout[d], overflow[d]); end
    end
  endtask

  task automatic test_basic_load();
    pulse_start(0);
    n_cmp++; if (s_ready[0] !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", s_ready[0]); end
    for (int i = 0; i < 4; i++) begin
      s_valid[0] = 1'b1;
      s_data[0]  = 64'hE3A0_0001 + 64'(i);
      s_last[0]  = (i == 3);
      push_exp(0, i, 64'hE3A0_0001 + 64'(i));
      @(negedge clk);
      n_cmp++; if (mem_we[0] !== 1'b1) begin n_err++; $display("FAIL basic_consecutive beat=%0d: got we=%b want 1", i, mem_we[0]); end
    end
    s_valid[0] = 1'b0;
    s_last[0]  = 1'b0;
    n_cmp++; if (word_count[0] !== 32'd4) begin n_err++; $display("FAIL basic_word_count: got %0d want 4", word_count[0]); end
    n_cmp++; if (core_rst[0] !== 1'b1 || s_ready[0] !== 1'b0) begin n_err++; $display("FAIL basic_after_last: got rst=%b ready=%b want 1/0", core_rst[0], s_ready[0]); end
    @(negedge clk);
    n_cmp++; if (core_rst[0] !== 1'b1 || mem_we[0] !== 1'b0) begin n_err++; $display("FAIL basic_flush: got rst=%b we=%b want 1/0", core_rst[0], mem_we[0]); end
    @(negedge clk);
    n_cmp++; if (core_rst[0] !== 1'b0 || cycle_count[0] !== 32'd0) begin n_err++; $display("FAIL basic_release: got rst=%b cyc=%0d want 0/0", core_rst[0], cycle_count[0]); end
  endtask

  task automatic test_halt();
    repeat (9) @(negedge clk);
    n_cmp++; if (cycle_count[0] !== 32'd9 || done[0] !== 1'b0) begin n_err++; $display("FAIL halt_pre: got cyc=%0d done=%b want 9/0", cycle_count[0], done[0]); end
    halted[0] = 1'b1;
    @(negedge clk);
    halted[0] = 1'b0;
    n_cmp++; if (done[0] !== 1'b1 || cycle_count[0] !== 32'd10) begin n_err++; $display("FAIL halt_done: got done=%b cyc=%0d want 1/10", done[0], cycle_count[0]); end
    n_cmp++; if (core_rst[0] !== 1'b0 || s_ready[0] !== 1'b0 || timeout[0] !== 1'b0) begin n_err++; $display("FAIL halt_status: got rst=%b ready=%b to=%b want 0/0/0", core_rst[0], s_ready[0], timeout[0]); end
    repeat (3) @(negedge clk);
    n_cmp++; if (done[0] !== 1'b1 || cycle_count[0] !== 32'd10) begin n_err++; $display("FAIL halt_hold: got done=%b cyc=%0d want 1/10", done[0], cycle_count[0]); end
  endtask

  task automatic test_back_to_back();
    pulse_start(0);
    n_cmp++; if (core_rst[0] !== 1'b1 || done[0] !== 1'b0) begin n_err++; $display("FAIL restart_status: got rst=%b done=%b want 1/0", core_rst[0], done[0]); end
    n_cmp++; if (cycle_count[0] !== 32'd0 || word_count[0] !== 32'd0 || s_ready[0] !== 1'b1) begin n_err++; $display("FAIL restart_counts: got cyc=%0d wc=%0d ready=%b want 0/0/1", cycle_count[0], word_count[0], s_ready[0]); end
    s_valid[0] = 1'b1; s_data[0] = 64'h1111_AAAA; push_exp(0, 0, 64'h1111_AAAA);
    @(negedge clk);
    n_cmp++; if (mem_we[0] !== 1'b1) begin n_err++; $display("FAIL bp_beat0: got we=%b want 1", mem_we[0]); end
    s_valid[0] = 1'b0; s_data[0] = 64'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (mem_we[0] !== 1'b0 || word_count[0] !== 32'd1) begin n_err++; $display("FAIL bp_idle: got we=%b wc=%0d want 0/1", mem_we[0], word_count[0]); end
    s_valid[0] = 1'b1; s_data[0] = 64'h2222_BBBB; push_exp(0, 1, 64'h2222_BBBB);
    @(negedge clk);
    s_valid[0] = 1'b0;
    n_cmp++; if (mem_we[0] !== 1'b1 || word_count[0] !== 32'd2) begin n_err++; $display("FAIL bp_beat1: got we=%b wc=%0d want 1/2", mem_we[0], word_count[0]); end
  endtask

  task automatic test_reset_mid_load();
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    n_cmp++; if (core_rst[0] !== 1'b1 || s_ready[0] !== 1'b0 || mem_we[0] !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got rst=%b ready=%b we=%b want 1/0/0", core_rst[0], s_ready[0], mem_we[0]); end
    n_cmp++; if (mem_addr[0] !== 32'h0 || mem_data[0] !== 64'h0 || word_count[0] !== 32'd0) begin n_err++; $display("FAIL midrst_regs: got addr=%h data=%h wc=%0d want 0/0/0", mem_addr[0], mem_data[0], word_count[0]); end
    s_valid[0] = 1'b1; s_data[0] = 64'h3333_CCCC;
    @(negedge clk);
    s_valid[0] = 1'b0;
    n_cmp++; if (mem_we[0] !== 1'b0 || s_ready[0] !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got we=%b ready=%b want 0/0", mem_we[0], s_ready[0]); end
  endtask

  task automatic test_timeout();
    pulse_start(1);
    send(1, 1, 1'b1, 1, 64'hE1A0_0000);
    repeat (6) @(negedge clk);
    n_cmp++; if (timeout[1] !== 1'b0 || core_rst[1] !== 1'b0 || cycle_count[1] !== 32'd4) begin n_err++; $display("FAIL to_pre: got to=%b rst=%b cyc=%0d want 0/0/4", timeout[1], core_rst[1], cycle_count[1]); end
    @(negedge clk);
    n_cmp++; if (timeout[1] !== 1'b1 || core_rst[1] !== 1'b1 || done[1] !== 1'b0) begin n_err++; $display("FAIL to_fire: got to=%b rst=%b done=%b want 1/1/0", timeout[1], core_rst[1], done[1]); end
    n_cmp++; if (cycle_count[1] !== 32'd5) begin n_err++; $display("FAIL to_cycles: got %0d want 5", cycle_count[1]); end
    // Halt arriving on the timeout cycle must win.
    pulse_start(1);
    n_cmp++; if (timeout[1] !== 1'b0 || core_rst[1] !== 1'b1) begin n_err++; $display("FAIL to_restart: got to=%b rst=%b want 0/1", timeout[1], core_rst[1]); end
    send(1, 1, 1'b1, 1, 64'hE1A0_1000);
    repeat (6) @(negedge clk);
    halted[1] = 1'b1;
    @(negedge clk);
    halted[1] = 1'b0;
    n_cmp++; if (done[1] !== 1'b1 || timeout[1] !== 1'b0 || core_rst[1] !== 1'b0) begin n_err++; $display("FAIL to_halt_wins: got done=%b to=%b rst=%b want 1/0/0", done[1], timeout[1], core_rst[1]); end
  endtask

  task automatic test_overflow();
    pulse_start(1);
    send(1, 3, 1'b0, 2, 64'hE2800000);
    n_cmp++; if (overflow[1] !== 1'b1 || core_rst[1] !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got ovf=%b rst=%b want 1/1", overflow[1], core_rst[1]); end
    n_cmp++; if (word_count[1] !== 32'd2 || mem_we[1] !== 1'b0 || s_ready[1] !== 1'b0) begin n_err++; $display("FAIL ovf_state: got wc=%0d we=%b ready=%b want 2/0/0", word_count[1], mem_we[1], s_ready[1]); end
    repeat (2) @(negedge clk);
    n_cmp++; if (overflow[1] !== 1'b1 || core_rst[1] !== 1'b1 || done[1] !== 1'b0) begin n_err++; $display("FAIL ovf_hold: got ovf=%b rst=%b done=%b want 1/1/0", overflow[1], core_rst[1], done[1]); end
  endtask

  task automatic test_params();
    pulse_start(2);
    send(2, 2, 1'b1, 2, 64'h0123_4567_89AB_CDEF);
    n_cmp++; if (word_count[2] !== 32'd2) begin n_err++; $display("FAIL p64_word_count: got %0d want 2", word_count[2]); end
    pulse_start(3);
    send(3, 2, 1'b1, 2, 64'hFEDC_BA98_7654_3210);
    repeat (2) @(negedge clk);
    n_cmp++; if (core_rst[3] !== 1'b0 || word_count[3] !== 32'd2) begin n_err++; $display("FAIL pwrap_run: got rst=%b wc=%0d want 0/2", core_rst[3], word_count[3]); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; s_valid[d] = 1'b0;
      s_last[d] = 1'b0; halted[d] = 1'b0; s_data[d] = 64'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
    test_reset();
    test_basic_load();
    test_halt();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    test_overflow();
    test_params();
    repeat (2) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL writes_missing: got %0d outstanding want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arm_image_loader.md
# arm_image_loader

Synthesizable program-image loader and run supervisor for the ARM core. It accepts a stream of instruction/data words over a valid/ready port and writes them into the unified memory's data port at consecutive addresses while it holds the core in reset. It then releases the core and watches `halted`, ending with done or timeout status. It moves preload, reset release and halt detection out of benches into RTL, adds parametrised width, base address, image depth and a run timeout, and supports repeated load/run sessions.

## Interface
Parameters:
- `DATA_WIDTH`, 32, stream word and memory write width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 32, memory byte-address width.
- `BASE_ADDR`, 0, byte address of the first image word.
- `MAX_WORDS`, 1024, image capacity in words; must be at least 1.
- `TIMEOUT_CYCLES`, 100000, run-cycle limit; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load session.
- `s_valid`  in  1  image beat valid.
- `s_data`  in  DATA_WIDTH  image word.
- `s_last`  in  1  marks the final beat of the image.
- `s_ready`  out  1  loader accepts a beat.
- `mem_addr`  out  ADDR_WIDTH  byte address for the write.
- `mem_data_in`  out  DATA_WIDTH  write data.
- `mem_write_en`  out  1  memory write strobe.
- `core_rst`  out  1  active-high reset to `arm_core`.
- `halted`  in  1  halt indication from `arm_core`.
- `done`  out  1  sticky flag: the core halted.
- `timeout`  out  1  sticky flag: the run limit expired.
- `overflow`  out  1  sticky flag: the image exceeded `MAX_WORDS`.
- `word_count`  out  clog2(MAX_WORDS+1)  number of words written in this session.
- `cycle_count`  out  32  number of cycles spent in RUN, saturating.

## Operation
- States:
  - IDLE: waiting for `start`.
  - LOAD: accepting image beats.
  - FLUSH: one guard cycle after the final write.
  - RUN: core released; waiting for halt or timeout.
  - DONE: core halted.
  - ERROR: overflow or timeout.
- Reset values (while `rst_n`=0 at an edge): state IDLE, `core_rst`=1, `s_ready`=0, `mem_write_en`=0, `mem_addr`=BASE_ADDR, `mem_data_in`=0, all counts and flags 0.
- IDLE to LOAD: when `start`=1. Clear all counts and flags. `s_ready` goes 1 from the next cycle.
- LOAD:
  - `s_ready`=1 while `word_count` < MAX_WORDS.
  - A beat is accepted on an edge where `s_valid` and `s_ready` are both 1.
  - An accepted beat registers `mem_write_en`=1, `mem_addr`=BASE_ADDR + word_count*(DATA_WIDTH/8) (truncated to ADDR_WIDTH, so the address wraps modulo 2^ADDR_WIDTH), `mem_data_in`=`s_data`, and increments `word_count`.
  - With no accepted beat, `mem_write_en` is 0 for that cycle.
  - An accepted beat with `s_last`=1 moves the state to FLUSH.
- Overflow: `s_valid`=1 while `word_count`=MAX_WORDS and no `s_last` has been seen. Result: state ERROR, `overflow`=1, nothing written, `core_rst` stays 1.
- FLUSH: `mem_write_en`=0 for one cycle, then RUN.
- RUN:
  - `core_rst`=0.
  - `cycle_count` increments each cycle and saturates at 2^32-1.
  - `halted`=1 moves to DONE with `done`=1 and `core_rst` staying 0, so the core state is observable.
  - If TIMEOUT_CYCLES≠0 and `cycle_count`=TIMEOUT_CYCLES-1 without halt: state ERROR, `timeout`=1, `core_rst`=1.
  - If halt and timeout occur on the same cycle, halt wins.
- DONE and ERROR hold until `start`=1. Then `core_rst`=1 on the next edge, counts and flags clear, and the state is LOAD.
- `start` is ignored in LOAD, FLUSH and RUN.
- `s_ready` is 0 in every state except LOAD.
- `rst_n`=0 in any state aborts the session at that edge. A partial image is left in memory and the core is reset.

## Timing
- Beat accepted at edge N: the write strobe is high during cycle N..N+1 and memory commits the word at edge N+1.
- Sustained throughput: one word per cycle, with no bubbles while `s_valid` stays 1.
- Final beat accepted at edge N: state FLUSH after N+1, state RUN and `core_rst`=0 after N+2, first core fetch at edge N+3.
- `halted` sampled 1 at edge M: `done`=1 after M.
- `cycle_count` reads 1 after the first RUN edge.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Basic load: reset, pulse `start`, stream 4 words 0xE3A00001..0xE3A00004 with `s_last` on the 4th. Expect writes to addresses 0, 4, 8, 12 in consecutive cycles, `word_count`=4, `core_rst` falling 2 edges after the last accepted beat.
- Halt: in RUN, drive `halted`=1 after 10 cycles. Expect `done`=1, `cycle_count`=10, `core_rst`=0, `s_ready`=0.
- Overflow: MAX_WORDS=2, stream 3 beats with no `s_last`. Expect 2 writes, `overflow`=1, no third write, `core_rst`=1.
- Timeout: TIMEOUT_CYCLES=5, `halted` held at 0. Expect `timeout`=1 after 5 RUN cycles and `core_rst`=1. A variant with `halted` rising on that same cycle expects `done`=1 and `timeout`=0.
- Parameters: DATA_WIDTH=64, BASE_ADDR=0x100, ADDR_WIDTH=12, 2 words. Expect addresses 0x100 and 0x108. A second run with BASE_ADDR=0xFF8 and 2 words expects addresses 0xFF8 then 0x000.
- Backpressure and reset: `s_valid` toggling 1,0,1. Expect writes only on accepting cycles. Assert `rst_n`=0 mid-LOAD: expect IDLE on the next edge with every output at its reset value.
